t03_muldiv_seq: RTL

T03_MULDIV_SEQ -- requirements
Module: t03_muldiv_seq

---
 rtl/t03_pkg.sv | 39 +++
 rtl/t03_ALU.sv | 61 ++++++
 rtl/t03_muldiv_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/t03_pkg.sv
// Shared types for the sequential multiply/divide unit: operation codes,
// ALU function codes, FSM states and the ALU flag bundle.
package t03_pkg;

  localparam int              CNT_W    = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = 6'd31;

  typedef enum logic [1:0] {
    MUL   = 2'd0,
    MULHU = 2'd1,
    DIVU  = 2'd2,
    REMU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [2:0] {
    FOP_ADD = 3'd0,
    FOP_SUB = 3'd1,
    FOP_AND = 3'd2,
    FOP_OR  = 3'd3,
    FOP_XOR = 3'd4
  } fop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic lt;
  } alu_flags_t;

  function automatic logic is_div(input muldiv_op_t o);
    return (o == DIVU) || (o == REMU);
  endfunction

endpackage

// File: rtl/t03_ALU.sv
// Small shared ALU: add/sub core with optional logic-op mux, optional
// 12-bit immediate sign extension on b, and signed/unsigned less-than flag.
module t03_ALU
  import t03_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit u          = 1'b1,
  parameter bit alu_mux_en = 1'b0,
  parameter bit imm_gen    = 1'b0
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  fop_t            fop,
  output logic [XLEN-1:0] y,
  output alu_flags_t      flags
);

  logic [XLEN-1:0] b_eff;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;

  generate
    if (imm_gen) begin : g_imm
      assign b_eff = {{(XLEN-12){b[11]}}, b[11:0]};
    end else begin : g_reg
      assign b_eff = b;
    end
  endgenerate

  assign sum  = a + b_eff;
  assign diff = a - b_eff;

  generate
    if (alu_mux_en) begin : g_mux
      always_comb begin
        y = sum;
        case (fop)
          FOP_SUB: y = diff;
          FOP_AND: y = a & b_eff;
          FOP_OR:  y = a | b_eff;
          FOP_XOR: y = a ^ b_eff;
          default: y = sum;
        endcase
      end
    end else begin : g_addsub
      assign y = (fop == FOP_SUB) ? diff : sum;
    end
  endgenerate

  generate
    if (u) begin : g_ult
      assign flags.lt = (a < b_eff);
    end else begin : g_slt
      assign flags.lt = ($signed(a) < $signed(b_eff));
    end
  endgenerate

  assign flags.zero = (y == '0);
  assign flags.neg  = y[XLEN-1];

endmodule

// File: rtl/t03_muldiv_seq.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one
// ALU; 32 CALC cycles per operation, divide-by-zero short-cuts straight to DONE.
module t03_muldiv_seq
  import t03_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start,
  input  logic            flush,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic            dbz,
  output logic [XLEN-1:0] result
);

  state_t           state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             dbz_q, dbz_d;

  logic             is_mul;
  logic             div_zero;
  logic             last_step;
  logic             shift_out;
  logic [XLEN-1:0]  r_shift;
  logic [XLEN-1:0]  q_shift;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_y;
  fop_t             alu_fop;
  alu_flags_t       alu_flags_unused;
  logic             carry;
  logic             take_sub;
  logic [XLEN-1:0]  step_hi;
  logic [XLEN-1:0]  step_lo;

  assign is_mul    = !is_div(op_q);
  assign div_zero  = is_div(op) && (opb == '0);
  assign last_step = (cnt_q == CNT_LAST);

  // hi_q doubles as the partial remainder, lo_q as the quotient for divides
  assign shift_out = hi_q[XLEN-1];
  assign r_shift   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
  assign q_shift   = {lo_q[XLEN-2:0], 1'b0};
  assign alu_a     = is_mul ? hi_q : r_shift;
  assign alu_fop   = is_mul ? FOP_ADD : FOP_SUB;

  t03_ALU #(
    .XLEN      (XLEN),
    .u         (1'b1),
    .alu_mux_en(1'b0),
    .imm_gen   (1'b0)
  ) u_alu (
    .a    (alu_a),
    .b    (b_q),
    .fop  (alu_fop),
    .y    (alu_y),
    .flags(alu_flags_unused)
  );

  always_comb begin
    step_hi  = hi_q;
    step_lo  = lo_q;
    carry    = (alu_y < hi_q);
    take_sub = shift_out || (r_shift >= b_q);
    if (is_mul) begin
      if (lo_q[0]) begin
        {step_hi, step_lo} = {carry, alu_y, lo_q[XLEN-1:1]};
      end else begin
        {step_hi, step_lo} = {1'b0, hi_q, lo_q[XLEN-1:1]};
      end
    end else begin
      step_hi = take_sub ? alu_y : r_shift;
      step_lo = {q_shift[XLEN-1:1], take_sub};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = div_zero ? ST_DONE : ST_CALC;
        ST_CALC: if (last_step) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Result and dbz are loaded on the edge into DONE so they are valid with done
  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    if (!flush) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d  = op;
            b_d   = opb;
            hi_d  = '0;
            lo_d  = opa;
            cnt_d = '0;
            if (div_zero) begin
              result_d = (op == DIVU) ? '1 : opa;
              dbz_d    = 1'b1;
            end
          end
        end
        ST_CALC: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 6'd1;
          if (last_step) begin
            result_d = ((op_q == MUL) || (op_q == DIVU)) ? step_lo : step_hi;
            dbz_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      op_q     <= MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result = result_q;
  assign dbz    = dbz_q;

endmodule
